uart_tx_buffered: RTL



---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx_buffered.sv | 101 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmitter and receiver.
// Frame format is 8N1 on an idle-high line.
package uart_pkg;

  typedef enum logic {
    IDLE,
    TRANSMITTING
  } uart_tx_state_t;

  localparam int UART_BAUD_DIV   = 2604;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..BAUD_DIV-1 while enabled.
// tick marks the last cycle of each bit period.
module uart_baud_tick #(
  parameter int BAUD_DIV = 2604
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 serial transmitter with a one-byte holding register,
// so a queued byte starts right after the previous stop bit.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_rdy,
  output logic       TX,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ovr
);

  localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

  uart_tx_state_t state;
  logic [7:0]     hold;
  logic [9:0]     shift_reg;
  logic [3:0]     bit_cnt;
  logic           tick;
  logic           frame_end;
  logic           load;
  logic           accept;

  assign frame_end = (state == TRANSMITTING) & tick & (bit_cnt == LAST_BIT);
  assign load      = ~tx_rdy & ((state == IDLE) | frame_end);
  assign accept    = trmt & tx_rdy;
  assign tx_busy   = (state == TRANSMITTING);
  assign TX        = shift_reg[0];

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (state == TRANSMITTING),
    .tick(tick)
  );

  // Holding register; load and accept are mutually exclusive via tx_rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold   <= '0;
      tx_rdy <= 1'b1;
      tx_ovr <= 1'b0;
    end else begin
      tx_ovr <= trmt & ~tx_rdy;
      if (load) begin
        tx_rdy <= 1'b1;
      end else if (accept) begin
        hold   <= tx_data;
        tx_rdy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '1;
      bit_cnt   <= '0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= frame_end;
      case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= {1'b1, hold, 1'b0};
            bit_cnt   <= '0;
            state     <= TRANSMITTING;
          end
        end
        TRANSMITTING: begin
          if (load) begin
            shift_reg <= {1'b1, hold, 1'b0};
            bit_cnt   <= '0;
          end else if (frame_end) begin
            shift_reg <= '1;
            bit_cnt   <= '0;
            state     <= IDLE;
          end else if (tick) begin
            shift_reg <= {1'b1, shift_reg[9:1]};
            bit_cnt   <= bit_cnt + 4'd1;
          end
        end
        default: begin
          shift_reg <= '1;
          bit_cnt   <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
